posit_mul_core: RTL and testbench

- Pipelined multiplier datapath for decoded posit operands.
- Sits directly downstream of the posit field decoder. Takes two decoded field sets (sign, regime, exponent, mantissa, type) and produces the exact product as sign, combined scale, normalized fraction and type.
- Output feeds the rounding/encoding stage.
- 3-stage pipeline with valid/ready handshake and global stall.

---
 rtl/posit_mul_core.sv | 190 +++++++++++++++++++
 tb/tb_posit_mul_core.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/posit_mul_core.sv
// posit_mul_core: exact multiplier for decoded posit operands.
//
// Three-stage pipeline between the posit field decoder and the rounding/encoding
// stage. Each operand arrives as sign, signed regime, exponent field, mantissa
// field (hidden bit excluded) and a 2-bit type. The result is the exact product
// expressed as sign, signed scale and normalized fraction, so that
// value = (1.frac_o) * 2^scale_o.
//
// Ports:
//   clk_i            clock, rising edge
//   rstn             asynchronous active-low reset
//   vld_i / rdy_o    operand handshake (rdy_o low while the output is blocked)
//   a_* / b_*        decoded operand fields
//   vld_o / rdy_i    result handshake
//   sign_o           product sign
//   scale_o          signed product scale
//   frac_o           product fraction, hidden bit excluded
//   type_o           00 zero, 01 valid, 10 NaR
//
// Stall model: a single enable freezes every stage, valid bits included, while
// a valid result sits at the output and downstream is not ready.

module posit_mul_core #(
  parameter int unsigned in_s    = 8,
  parameter int unsigned exp_s   = 2,
  localparam int unsigned reg_s  = $clog2(in_s) + 1,
  localparam int unsigned mts_s  = in_s - 3 - exp_s,
  localparam int unsigned sc_s   = reg_s + exp_s + 1,
  localparam int unsigned fr_s   = 2 * mts_s + 1
) (
  input  logic             clk_i,
  input  logic             rstn,
  input  logic             vld_i,
  output logic             rdy_o,
  input  logic             a_sign,
  input  logic             b_sign,
  input  logic [reg_s-1:0] a_regi,
  input  logic [reg_s-1:0] b_regi,
  input  logic [exp_s-1:0] a_exp,
  input  logic [exp_s-1:0] b_exp,
  input  logic [mts_s-1:0] a_mts,
  input  logic [mts_s-1:0] b_mts,
  input  logic [1:0]       a_type,
  input  logic [1:0]       b_type,
  output logic             vld_o,
  input  logic             rdy_i,
  output logic             sign_o,
  output logic [sc_s-1:0]  scale_o,
  output logic [fr_s-1:0]  frac_o,
  output logic [1:0]       type_o
);

  localparam int unsigned man_s = mts_s + 1;
  localparam int unsigned p_s   = 2 * mts_s + 2;
  localparam int unsigned ext_s = sc_s - reg_s - exp_s;

  localparam logic [1:0] TypeZero  = 2'b00;
  localparam logic [1:0] TypeValid = 2'b01;
  localparam logic [1:0] TypeNar   = 2'b10;

  logic en;

  // Stage 1: capture
  logic             s1_vld_q,     s1_vld_d;
  logic             s1_sign_q,    s1_sign_d;
  logic [1:0]       s1_type_q,    s1_type_d;
  logic [sc_s-1:0]  s1_scale_a_q, s1_scale_a_d;
  logic [sc_s-1:0]  s1_scale_b_q, s1_scale_b_d;
  logic [man_s-1:0] s1_man_a_q,   s1_man_a_d;
  logic [man_s-1:0] s1_man_b_q,   s1_man_b_d;

  // Stage 2: multiply and add
  logic             s2_vld_q,   s2_vld_d;
  logic             s2_sign_q,  s2_sign_d;
  logic [1:0]       s2_type_q,  s2_type_d;
  logic [sc_s-1:0]  s2_scale_q, s2_scale_d;
  logic [p_s-1:0]   s2_prod_q,  s2_prod_d;

  // Stage 3: normalize
  logic             s3_vld_q,   s3_vld_d;
  logic             s3_sign_q,  s3_sign_d;
  logic [1:0]       s3_type_q,  s3_type_d;
  logic [sc_s-1:0]  s3_scale_q, s3_scale_d;
  logic [fr_s-1:0]  s3_frac_q,  s3_frac_d;

  assign en    = ~(s3_vld_q & ~rdy_i);
  assign rdy_o = en;

  always_comb begin
    s1_vld_d     = vld_i;
    s1_sign_d    = a_sign ^ b_sign;
    // {regi, exp} is regi * 2^exp_s + exp; sign-extend it to the scale width.
    s1_scale_a_d = {{ext_s{a_regi[reg_s-1]}}, a_regi, a_exp};
    s1_scale_b_d = {{ext_s{b_regi[reg_s-1]}}, b_regi, b_exp};
    s1_man_a_d   = {1'b1, a_mts};
    s1_man_b_d   = {1'b1, b_mts};
    // Type 11 is folded into NaR via the upper bit.
    if (a_type[1] | b_type[1]) begin
      s1_type_d = TypeNar;
    end else if ((a_type == TypeZero) || (b_type == TypeZero)) begin
      s1_type_d = TypeZero;
    end else begin
      s1_type_d = TypeValid;
    end
  end

  always_comb begin
    s2_vld_d   = s1_vld_q;
    s2_sign_d  = s1_sign_q;
    s2_type_d  = s1_type_q;
    // Both scales fit in reg_s+exp_s bits, so the sum cannot overflow sc_s.
    s2_scale_d = s1_scale_a_q + s1_scale_b_q;
    s2_prod_d  = p_s'(s1_man_a_q) * p_s'(s1_man_b_q);
  end

  always_comb begin
    s3_vld_d   = s2_vld_q;
    s3_type_d  = s2_type_q;
    s3_sign_d  = s2_sign_q;
    // Product of two [1,2) mantissas lies in [1,4): at most one shift needed.
    if (s2_prod_q[p_s-1]) begin
      s3_frac_d  = s2_prod_q[fr_s-1:0];
      s3_scale_d = s2_scale_q + sc_s'(1);
    end else begin
      s3_frac_d  = {s2_prod_q[fr_s-2:0], 1'b0};
      s3_scale_d = s2_scale_q;
    end
    if (s2_type_q != TypeValid) begin
      s3_sign_d  = 1'b0;
      s3_scale_d = '0;
      s3_frac_d  = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rstn) begin
    if (!rstn) begin
      s1_vld_q     <= 1'b0;
      s1_sign_q    <= 1'b0;
      s1_type_q    <= TypeZero;
      s1_scale_a_q <= '0;
      s1_scale_b_q <= '0;
      s1_man_a_q   <= '0;
      s1_man_b_q   <= '0;
      s2_vld_q     <= 1'b0;
      s2_sign_q    <= 1'b0;
      s2_type_q    <= TypeZero;
      s2_scale_q   <= '0;
      s2_prod_q    <= '0;
      s3_vld_q     <= 1'b0;
      s3_sign_q    <= 1'b0;
      s3_type_q    <= TypeZero;
      s3_scale_q   <= '0;
      s3_frac_q    <= '0;
    end else if (en) begin
      s1_vld_q     <= s1_vld_d;
      s1_sign_q    <= s1_sign_d;
      s1_type_q    <= s1_type_d;
      s1_scale_a_q <= s1_scale_a_d;
      s1_scale_b_q <= s1_scale_b_d;
      s1_man_a_q   <= s1_man_a_d;
      s1_man_b_q   <= s1_man_b_d;
      s2_vld_q     <= s2_vld_d;
      s2_sign_q    <= s2_sign_d;
      s2_type_q    <= s2_type_d;
      s2_scale_q   <= s2_scale_d;
      s2_prod_q    <= s2_prod_d;
      s3_vld_q     <= s3_vld_d;
      s3_sign_q    <= s3_sign_d;
      s3_type_q    <= s3_type_d;
      s3_scale_q   <= s3_scale_d;
      s3_frac_q    <= s3_frac_d;
    end
  end

  // Stale data in a bubble must never be visible downstream.
  always_comb begin
    vld_o   = s3_vld_q;
    sign_o  = 1'b0;
    scale_o = '0;
    frac_o  = '0;
    type_o  = TypeZero;
    if (s3_vld_q) begin
      sign_o  = s3_sign_q;
      scale_o = s3_scale_q;
      frac_o  = s3_frac_q;
      type_o  = s3_type_q;
    end
  end

endmodule

// File: tb/tb_posit_mul_core.sv
module tb_posit_mul_core;

  typedef struct packed {
    logic       s;
    logic [3:0] r;
    logic [1:0] e;
    logic [2:0] m;
    logic [1:0] t;
  } opnd_t;

  typedef struct packed {
    logic       sign;
    logic [6:0] scale;
    logic [6:0] frac;
    logic [1:0] typ;
  } res_t;

  logic       clk_i = 1'b0;
  logic       rstn;
  logic       vld_i, rdy_o, vld_o, rdy_i;
  logic       a_sign, b_sign, sign_o;
  logic [3:0] a_regi, b_regi;
  logic [1:0] a_exp, b_exp, a_type, b_type, type_o;
  logic [2:0] a_mts, b_mts;
  logic [6:0] scale_o, frac_o;

  int n_vec = 0;
  int n_err = 0;
  res_t sb_q[$];
  res_t held;
  logic held_v = 1'b0;

  posit_mul_core dut (
    .clk_i   (clk_i),
    .rstn    (rstn),
    .vld_i   (vld_i),
    .rdy_o   (rdy_o),
    .a_sign  (a_sign),
    .b_sign  (b_sign),
    .a_regi  (a_regi),
    .b_regi  (b_regi),
    .a_exp   (a_exp),
    .b_exp   (b_exp),
    .a_mts   (a_mts),
    .b_mts   (b_mts),
    .a_type  (a_type),
    .b_type  (b_type),
    .vld_o   (vld_o),
    .rdy_i   (rdy_i),
    .sign_o  (sign_o),
    .scale_o (scale_o),
    .frac_o  (frac_o),
    .type_o  (type_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic res_t got_res();
    res_t g;
    g.sign  = sign_o;
    g.scale = scale_o;
    g.frac  = frac_o;
    g.typ   = type_o;
    return g;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Monitor: samples late in the low phase, after the driver has settled.
  always @(negedge clk_i) begin
    #2;
    if (rstn) begin
      if (vld_o && rdy_i) begin
        held_v = 1'b0;
        n_vec++;
        if (sb_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_result: got %h, expected no result", got_res());
        end else begin
          res_t e;
          e = sb_q.pop_front();
          if (got_res() !== e) begin
            n_err++;
            $display("FAIL result: got %h, expected %h", got_res(), e);
          end
        end
      end else if (vld_o) begin
        check("rdy_o_stalled", 32'(rdy_o), 32'd0);
        if (held_v) check("held_stable", 32'(got_res()), 32'(held));
        held   = got_res();
        held_v = 1'b1;
      end else begin
        held_v = 1'b0;
        check("idle_outputs_zero", 32'(got_res()), 32'd0);
        check("idle_rdy_o", 32'(rdy_o), 32'd1);
      end
    end
  end

  task automatic issue(input opnd_t a, input opnd_t b, input res_t r);
    int k;
    @(negedge clk_i);
    a_sign = a.s; a_regi = a.r; a_exp = a.e; a_mts = a.m; a_type = a.t;
    b_sign = b.s; b_regi = b.r; b_exp = b.e; b_mts = b.m; b_type = b.t;
    vld_i  = 1'b1;
    #1;
    k = 0;
    while (!rdy_o && k < 40) begin
      @(negedge clk_i);
      #1;
      k++;
    end
    if (!rdy_o) begin
      n_vec++;
      n_err++;
      $display("FAIL issue_timeout: rdy_o=%b, expected 1", rdy_o);
    end else begin
      sb_q.push_back(r);
    end
  endtask

  task automatic idle();
    @(negedge clk_i);
    vld_i = 1'b0;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (sb_q.size() != 0 && k < 60) begin
      @(negedge clk_i);
      k++;
    end
    repeat (2) @(negedge clk_i);
    check("drain_pending", 32'(sb_q.size()), 32'd0);
  endtask

  // Directed operands: {sign, regime, exp, mts, type}
  localparam opnd_t OpA3  = '{s:1'b0, r:4'd0,  e:2'd1, m:3'b100, t:2'b01};
  localparam opnd_t OpB16 = '{s:1'b0, r:4'd1,  e:2'd0, m:3'b000, t:2'b01};
  localparam opnd_t OpMxN = '{s:1'b1, r:4'hF,  e:2'd3, m:3'b111, t:2'b01};
  localparam opnd_t OpMxP = '{s:1'b0, r:4'hF,  e:2'd3, m:3'b111, t:2'b01};
  localparam opnd_t OpNar = '{s:1'b1, r:4'd3,  e:2'd2, m:3'b101, t:2'b10};
  localparam opnd_t OpZer = '{s:1'b1, r:4'd2,  e:2'd1, m:3'b011, t:2'b00};
  localparam opnd_t OpOne = '{s:1'b0, r:4'd0,  e:2'd0, m:3'b000, t:2'b01};
  localparam opnd_t OpC1  = '{s:1'b0, r:4'hE,  e:2'd2, m:3'b010, t:2'b01};
  localparam opnd_t OpC2  = '{s:1'b1, r:4'd0,  e:2'd3, m:3'b001, t:2'b01};
  localparam opnd_t OpD1  = '{s:1'b1, r:4'd3,  e:2'd3, m:3'b111, t:2'b01};
  localparam opnd_t OpD2  = '{s:1'b1, r:4'd2,  e:2'd1, m:3'b110, t:2'b01};
  localparam opnd_t OpE1  = '{s:1'b0, r:4'h8,  e:2'd0, m:3'b001, t:2'b01};
  localparam opnd_t OpE2  = '{s:1'b0, r:4'd7,  e:2'd3, m:3'b011, t:2'b01};

  // Expected: 12*8=96 -> 01100000, S=5; 15*15=225 -> 11100001, S=-2+1
  localparam res_t R48   = '{sign:1'b0, scale:7'd5,   frac:7'b1000000, typ:2'b01};
  localparam res_t RMx   = '{sign:1'b1, scale:7'h7F,  frac:7'b1100001, typ:2'b01};
  localparam res_t RNar  = '{sign:1'b0, scale:7'd0,   frac:7'd0,       typ:2'b10};
  localparam res_t RZero = '{sign:1'b0, scale:7'd0,   frac:7'd0,       typ:2'b00};
  // 8*8=64 S=0; 10*9=90 S=-6+3; 15*14=210 S=15+9+1; 9*11=99 S=-32+31
  localparam res_t ROne  = '{sign:1'b0, scale:7'd0,   frac:7'b0000000, typ:2'b01};
  localparam res_t RC    = '{sign:1'b1, scale:7'h7D,  frac:7'b0110100, typ:2'b01};
  localparam res_t RD    = '{sign:1'b0, scale:7'd25,  frac:7'b1010010, typ:2'b01};
  localparam res_t RE    = '{sign:1'b0, scale:7'h7F,  frac:7'b1000110, typ:2'b01};

  initial begin
    rstn  = 1'b0;
    vld_i = 1'b0;
    rdy_i = 1'b1;
    a_sign = 1'b0; a_regi = '0; a_exp = '0; a_mts = '0; a_type = '0;
    b_sign = 1'b0; b_regi = '0; b_exp = '0; b_mts = '0; b_type = '0;
    #1;
    check("reset_vld_o", 32'(vld_o), 32'd0);
    check("reset_outputs", 32'(got_res()), 32'd0);
    #21 rstn = 1'b1;
    repeat (10) @(negedge clk_i);

    // Basic products, then type resolution with nonzero fields
    issue(OpA3, OpB16, R48);
    issue(OpMxN, OpMxP, RMx);
    issue(OpNar, OpOne, RNar);
    issue(OpZer, OpNar, RNar);
    issue(OpZer, OpZer, RZero);
    idle();
    drain();

    // Four back-to-back ops with downstream stalled in the middle
    fork
      begin
        issue(OpOne, OpOne, ROne);
        issue(OpC1, OpC2, RC);
        issue(OpD1, OpD2, RD);
        issue(OpE1, OpE2, RE);
        idle();
      end
      begin
        repeat (3) @(negedge clk_i);
        rdy_i = 1'b0;
        repeat (5) @(negedge clk_i);
        rdy_i = 1'b1;
      end
    join
    drain();

    // Reset with results in flight: none may appear afterwards
    issue(OpA3, OpB16, R48);
    issue(OpOne, OpOne, ROne);
    issue(OpD1, OpD2, RD);
    @(posedge clk_i);
    #1;
    vld_i = 1'b0;
    check("pre_reset_vld_o", 32'(vld_o), 32'd1);
    #1 rstn = 1'b0;
    #1;
    check("async_reset_vld_o", 32'(vld_o), 32'd0);
    check("async_reset_outputs", 32'(got_res()), 32'd0);
    sb_q.delete();
    #9 rstn = 1'b1;
    repeat (12) @(negedge clk_i);
    #3;
    check("post_reset_rdy_o", 32'(rdy_o), 32'd1);
    check("post_reset_pending", 32'(sb_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
